// File: rtl/adc_scan_seq_if.sv
// adc_scan_seq_if: bundles the sequencer's SAR-core handshake and its result
// stream.
//   start_conv  one-cycle conversion start pulse to the SAR core
//   adc_ch_no   channel being converted
//   conv_done   SAR done level; a rising edge marks completion
//   adc_result  SAR result, valid while conv_done is high
//   res_valid   one-cycle pulse qualifying res_ch/res_data
//   res_ch      channel of the averaged result
//   res_data    averaged result
//   scan_done   one-cycle pulse after the last enabled channel of a scan
// The master modport is the sequencer. The slave modport is the SAR core
// together with the result consumer.
interface adc_scan_seq_if;
  logic       start_conv;
  logic [2:0] adc_ch_no;
  logic       conv_done;
  logic [7:0] adc_result;
  logic       res_valid;
  logic [2:0] res_ch;
  logic [7:0] res_data;
  logic       scan_done;

  modport master (
    output start_conv, adc_ch_no, res_valid, res_ch, res_data, scan_done,
    input  conv_done, adc_result
  );

  modport slave (
    input  start_conv, adc_ch_no, res_valid, res_ch, res_data, scan_done,
    output conv_done, adc_result
  );
endinterface

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: autonomous channel-scan sequencer for the SAR ADC.
// The block walks the enabled channels in ascending order. For each channel
// it takes 2^avg_log2 conversions and issues one truncated average. Scans
// repeat back-to-back, or after cfg_interval 1 MHz ticks.
//   mclk, reset    clock and synchronous active-high reset
//   cfg_enable     scan enable level
//   cfg_ch_mask    enabled channels
//   cfg_avg_log2   log2 of the samples per channel
//   cfg_interval   1 MHz ticks between scan starts (0 = back-to-back)
//   pulse1m_mclk   1 MHz tick, one mclk wide
//   bus            SAR handshake and result stream (master side)
//   busy           high whenever the block is not idle
//   timeout_err    sticky lost-conversion flag
module adc_scan_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [5:0]           cfg_ch_mask,
  input  logic [1:0]           cfg_avg_log2,
  input  logic [15:0]          cfg_interval,
  input  logic                 pulse1m_mclk,
  adc_scan_seq_if.master       bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WAIT_INT, START, CONV, NEXT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [5:0]  mask_sh_q, mask_sh_d;
  logic [1:0]  avg_sh_q, avg_sh_d;
  logic [15:0] int_sh_q, int_sh_d;
  logic [15:0] int_cnt_q, int_cnt_d;
  logic [10:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        conv_done_q;
  logic        en_q;
  logic        start_conv_q, start_conv_d;
  logic        res_valid_q, res_valid_d;
  logic [2:0]  res_ch_q, res_ch_d;
  logic [7:0]  res_data_q, res_data_d;
  logic        scan_done_q, scan_done_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;

  logic        first_found, nxt_found;
  logic [2:0]  first_ch, nxt_ch;
  logic        conv_edge;
  logic [10:0] sum;
  logic [3:0]  cnt_inc, n_samples;

  // Lowest channel of the live mask, and the next enabled channel above the
  // current one in the shadow mask.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!first_found && cfg_ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = 3'(i);
      end
      if (!nxt_found && mask_sh_q[i] && (i > 32'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
    end
  end

  assign conv_edge = bus.conv_done & ~conv_done_q;
  assign sum       = acc_q + 11'(bus.adc_result);
  assign cnt_inc   = cnt_q + 4'd1;
  assign n_samples = 4'd1 << avg_sh_q;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    mask_sh_d     = mask_sh_q;
    avg_sh_d      = avg_sh_q;
    int_sh_d      = int_sh_q;
    int_cnt_d     = int_cnt_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    res_valid_d   = 1'b0;
    scan_done_d   = 1'b0;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q & ~(cfg_enable & ~en_q);

    if (pulse1m_mclk && (int_cnt_q != '0)) begin
      int_cnt_d = int_cnt_q - 16'd1;
    end

    unique case (state_q)
      IDLE, WAIT_INT: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if ((state_q == IDLE) || (int_cnt_q == '0)) begin
          if (first_found) begin
            mask_sh_d = cfg_ch_mask;
            avg_sh_d  = cfg_avg_log2;
            int_sh_d  = cfg_interval;
            int_cnt_d = cfg_interval;
            ch_d      = first_ch;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        // Result and scan_done are decided on leaving CONV so that they are
        // visible during NEXT, one cycle after the done edge.
        if (conv_edge) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if ((cnt_inc < n_samples) && cfg_enable) begin
            state_d = START;
          end else begin
            state_d = NEXT;
            scan_done_d = !nxt_found;
            if (cnt_inc >= n_samples) begin
              res_valid_d = 1'b1;
              res_ch_d    = ch_q;
              res_data_d  = 8'(sum >> avg_sh_q);
            end
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          scan_done_d   = !nxt_found;
          state_d       = NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      NEXT: begin
        acc_d = '0;
        cnt_d = '0;
        // Disabling mid-scan abandons the remaining channels. On the last
        // channel the scan has already completed with scan_done.
        if (nxt_found) begin
          if (cfg_enable) begin
            ch_d    = nxt_ch;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else if (!cfg_enable || (int_sh_q == '0)) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_INT;
        end
      end
      default: state_d = IDLE;
    endcase

    start_conv_d = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      mask_sh_q     <= '0;
      avg_sh_q      <= '0;
      int_sh_q      <= '0;
      int_cnt_q     <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      conv_done_q   <= 1'b0;
      en_q          <= 1'b0;
      start_conv_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      scan_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      mask_sh_q     <= mask_sh_d;
      avg_sh_q      <= avg_sh_d;
      int_sh_q      <= int_sh_d;
      int_cnt_q     <= int_cnt_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      conv_done_q   <= bus.conv_done;
      en_q          <= cfg_enable;
      start_conv_q  <= start_conv_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      scan_done_q   <= scan_done_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.start_conv = start_conv_q;
  assign bus.adc_ch_no  = ch_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.res_data   = res_data_q;
  assign bus.scan_done  = scan_done_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: scenario tasks for adc_scan_seq. A SAR core model answers
// start_conv after a random latency. A monitor logs results, starts and
// ticks. Expected results come from the channel-mask / averaging rules,
// applied to the values the SAR model handed out.
module tb_adc_scan_seq;
  localparam int unsigned TMO = 40;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [5:0]  cfg_ch_mask = '0;
  logic [1:0]  cfg_avg_log2 = '0;
  logic [15:0] cfg_interval = '0;
  logic        pulse1m_mclk;
  logic        busy, timeout_err;

  adc_scan_seq_if bus();

  adc_scan_seq #(.TIMEOUT(TMO)) dut (
    .mclk(mclk), .reset(reset), .cfg_enable(cfg_enable),
    .cfg_ch_mask(cfg_ch_mask), .cfg_avg_log2(cfg_avg_log2),
    .cfg_interval(cfg_interval), .pulse1m_mclk(pulse1m_mclk),
    .bus(bus), .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  initial forever begin @(posedge mclk); cyc++; end

  // SAR core model
  logic [7:0]  fixed_val [8];
  bit          fixed_en = 1'b0;
  logic [7:0]  script [$];
  logic [7:0]  hang_mask = '0;
  logic [10:0] conv_log [$];

  initial begin : sar_model
    int pend;
    logic [7:0] v;
    pend = 0;
    bus.conv_done  = 1'b0;
    bus.adc_result = '0;
    forever begin
      @(posedge mclk); #2;
      if (reset) begin
        bus.conv_done = 1'b0;
        pend = 0;
      end else if (bus.start_conv) begin
        bus.conv_done = 1'b0;
        pend = $urandom_range(4, 2);
      end else if (pend > 1) begin
        pend--;
      end else if (pend == 1 && !hang_mask[bus.adc_ch_no]) begin
        if (script.size() > 0) v = script.pop_front();
        else if (fixed_en) v = fixed_val[bus.adc_ch_no];
        else v = 8'($urandom);
        bus.adc_result = v;
        bus.conv_done  = 1'b1;
        conv_log.push_back({bus.adc_ch_no, v});
        pend = 0;
      end
    end
  end

  // 1 MHz tick generator
  bit pulse_run = 1'b0;
  int pulse_per = 7;
  int pulse_phase = 0;
  initial begin
    pulse1m_mclk = 1'b0;
    forever begin
      @(posedge mclk); #2;
      pulse1m_mclk = pulse_run && ((cyc % pulse_per) == pulse_phase);
    end
  end

  // Monitor
  logic [11:0] res_log [$];
  int start_log [$];
  int start_cyc [$];
  int pulse_cyc [$];
  int scan_cnt = 0;
  bit ch1_seen = 1'b0;
  initial forever begin
    @(negedge mclk);
    if (bus.res_valid) res_log.push_back({bus.scan_done, bus.res_ch, bus.res_data});
    if (bus.start_conv) begin
      start_log.push_back(int'(bus.adc_ch_no));
      start_cyc.push_back(cyc);
    end
    if (bus.scan_done) scan_cnt++;
    if (pulse1m_mclk) pulse_cyc.push_back(cyc);
    if (busy && bus.adc_ch_no == 3'd1) ch1_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge mclk); #2;
  endtask

  task automatic clear_logs();
    res_log.delete(); start_log.delete(); start_cyc.delete();
    pulse_cyc.delete(); conv_log.delete(); scan_cnt = 0; ch1_seen = 1'b0;
  endtask

  task automatic wait_scans(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge mclk); #1;
      if (scan_cnt >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_res(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge mclk); #1;
      if (res_log.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_starts(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge mclk); #1;
      if (start_log.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic go_idle(output bit ok);
    step();
    cfg_enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 * TMO && !ok; i++) begin
      @(negedge mclk); #1;
      if (!busy) ok = 1'b1;
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    @(negedge mclk);
    n_cmp++;
    if ({bus.start_conv, bus.adc_ch_no, bus.res_valid, bus.res_ch, bus.res_data,
         bus.scan_done, busy, timeout_err} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000000", {bus.start_conv, bus.adc_ch_no,
               bus.res_valid, bus.res_ch, bus.res_data, bus.scan_done, busy, timeout_err});
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    logic [11:0] exp;
    fixed_val[0] = 8'h40; fixed_val[2] = 8'hC3; fixed_en = 1'b1;
    cfg_ch_mask = 6'b000101; cfg_avg_log2 = 2'd0; cfg_interval = 16'd0;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    @(negedge mclk);
    n_cmp++;
    if (bus.start_conv !== 1'b0) begin
      n_fail++; $display("FAIL basic_no_early_start: start_conv=%b want 0", bus.start_conv);
    end
    @(negedge mclk);
    n_cmp++;
    if ({bus.start_conv, bus.adc_ch_no, busy} !== {1'b1, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_start_latency: start/ch/busy=%b/%0d/%b want 1/0/1",
               bus.start_conv, bus.adc_ch_no, busy);
    end
    wait_scans(3, 300, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_three_scans: scans=%0d want 3", scan_cnt); end
    go_idle(ok);
    n_cmp++;
    if (res_log.size() != 6) begin
      n_fail++; $display("FAIL basic_res_count: got %0d want 6", res_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp = (i % 2 == 0) ? {1'b0, 3'd0, 8'h40} : {1'b1, 3'd2, 8'hC3};
        n_cmp++;
        if (res_log[i] !== exp) begin
          n_fail++; $display("FAIL basic_res[%0d]: got %h want %h", i, res_log[i], exp);
        end
      end
    end
    n_cmp++;
    if (ch1_seen) begin n_fail++; $display("FAIL basic_ch1_never: ch1 seen=1 want 0"); end
    fixed_en = 1'b0;
  endtask

  task automatic test_average();
    bit ok;
    script = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd81};
    cfg_ch_mask = 6'b001000; cfg_avg_log2 = 2'd3; cfg_interval = 16'd100;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    wait_scans(1, 300, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL avg_scan_done: scans=%0d want 1", scan_cnt); end
    n_cmp++;
    if (start_log.size() != 8) begin
      n_fail++; $display("FAIL avg_start_count: got %0d want 8", start_log.size());
    end
    n_cmp++;
    if (res_log.size() != 1 || res_log[0] !== {1'b1, 3'd3, 8'd45}) begin
      n_fail++; $display("FAIL avg_result: got n=%0d first=%h want n=1 %h",
                         res_log.size(), res_log.size() ? res_log[0] : 12'h0, {1'b1, 3'd3, 8'd45});
    end
    go_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL avg_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_random_scans();
    bit ok;
    logic [5:0] mask;
    int avg, idx, sum, nres, last_ch;
    logic [11:0] exp;
    for (int it = 0; it < 6; it++) begin
      mask = 6'($urandom_range(63, 1));
      avg  = $urandom_range(3, 0);
      cfg_ch_mask = mask; cfg_avg_log2 = 2'(avg); cfg_interval = 16'd0;
      clear_logs();
      step();
      cfg_enable = 1'b1;
      wait_scans(1, 800, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rand_scan_done[%0d]: scans=%0d want 1", it, scan_cnt); end
      go_idle(ok);
      last_ch = 0;
      for (int c = 0; c < 6; c++) if (mask[c]) last_ch = c;
      n_cmp++;
      if (conv_log.size() != $countones(mask) * (1 << avg) || res_log.size() != $countones(mask)) begin
        n_fail++;
        $display("FAIL rand_counts[%0d]: conv=%0d res=%0d want conv=%0d res=%0d", it,
                 conv_log.size(), res_log.size(), $countones(mask) * (1 << avg), $countones(mask));
      end else begin
        idx = 0; nres = 0;
        for (int c = 0; c < 6; c++) begin
          if (mask[c]) begin
            sum = 0;
            for (int k = 0; k < (1 << avg); k++) begin
              n_cmp++;
              if (conv_log[idx][10:8] !== 3'(c)) begin
                n_fail++; $display("FAIL rand_conv_ch[%0d]: got %0d want %0d", it, conv_log[idx][10:8], c);
              end
              sum += int'(conv_log[idx][7:0]);
              idx++;
            end
            exp = {(c == last_ch) ? 1'b1 : 1'b0, 3'(c), 8'(sum / (1 << avg))};
            n_cmp++;
            if (res_log[nres] !== exp) begin
              n_fail++; $display("FAIL rand_res[%0d.%0d]: got %h want %h", it, nres, res_log[nres], exp);
            end
            nres++;
          end
        end
      end
    end
  endtask

  task automatic test_interval();
    bit ok;
    int s0, s1, p3, cnt;
    cfg_ch_mask = 6'b010000; cfg_avg_log2 = 2'd0; cfg_interval = 16'd3;
    pulse_per = 7; pulse_phase = $urandom_range(6, 0); pulse_run = 1'b1;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    wait_starts(2, 300, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL interval_second_scan: starts=%0d want 2", start_log.size()); end
    go_idle(ok);
    pulse_run = 1'b0;
    if (start_cyc.size() >= 2) begin
      s0 = start_cyc[0]; s1 = start_cyc[1];
      cnt = 0; p3 = -1;
      foreach (pulse_cyc[i]) begin
        if (pulse_cyc[i] >= s0 && cnt < 3) begin
          cnt++;
          if (cnt == 3) p3 = pulse_cyc[i];
        end
      end
      n_cmp++;
      if (p3 < 0 || s1 <= p3 || s1 > p3 + 2) begin
        n_fail++; $display("FAIL interval_timing: second start cycle %0d, third tick %0d, want (tick, tick+2]", s1, p3);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int s, r;
    cfg_ch_mask = 6'b000110; cfg_avg_log2 = 2'd0; cfg_interval = 16'd0;
    hang_mask = 8'b0000_0010;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    wait_starts(1, 20, ok);
    s = (start_cyc.size() > 0) ? start_cyc[0] : 0;
    r = -1;
    for (int i = 0; i < int'(TMO) + 20 && r < 0; i++) begin
      @(negedge mclk); #1;
      if (timeout_err === 1'b1) r = cyc;
    end
    n_cmp++;
    if (r < 0 || r - s < int'(TMO) || r - s > int'(TMO) + 2) begin
      n_fail++; $display("FAIL timeout_latency: rise after %0d cycles want %0d..%0d", r - s, TMO, TMO + 2);
    end
    wait_scans(1, 100, ok);
    n_cmp++;
    if (!ok || res_log.size() != 1 || res_log[0][11:8] !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL timeout_skip_ch1: n=%0d first=%h want one ch2 result with scan_done",
                         res_log.size(), res_log.size() ? res_log[0] : 12'h0);
    end
    go_idle(ok);
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    cfg_enable = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear_on_enable: got %b want 0", timeout_err); end
    hang_mask = '0;
    go_idle(ok);
  endtask

  task automatic test_mask_change_and_disable();
    bit ok;
    int exp_ch [5] = '{0, 1, 4, 5, 4};
    bit exp_sd [5] = '{0, 1, 0, 1, 0};
    cfg_ch_mask = 6'b000011; cfg_avg_log2 = 2'd0; cfg_interval = 16'd0;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    wait_res(1, 50, ok);
    step();
    cfg_ch_mask = 6'b110000;
    wait_starts(5, 200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL maskchg_starts: got %0d want 5", start_log.size()); end
    step();
    cfg_enable = 1'b0;
    go_idle(ok);
    n_cmp++;
    if (busy !== 1'b0 || scan_cnt != 2 || start_log.size() != 5) begin
      n_fail++; $display("FAIL disable_idle: busy=%b scans=%0d starts=%0d want 0/2/5",
                         busy, scan_cnt, start_log.size());
    end
    n_cmp++;
    if (res_log.size() != 5 || conv_log.size() != 5) begin
      n_fail++; $display("FAIL maskchg_res_count: res=%0d conv=%0d want 5/5", res_log.size(), conv_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (res_log[i] !== {exp_sd[i], 3'(exp_ch[i]), conv_log[i][7:0]}) begin
          n_fail++; $display("FAIL maskchg_res[%0d]: got %h want %h", i, res_log[i],
                             {exp_sd[i], 3'(exp_ch[i]), conv_log[i][7:0]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    bit ok;
    cfg_ch_mask = 6'b000001; cfg_avg_log2 = 2'd2; cfg_interval = 16'd0;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    wait_starts(2, 50, ok);
    step();
    reset = 1'b1;
    cfg_enable = 1'b0;
    step();
    reset = 1'b0;
    @(negedge mclk);
    n_cmp++;
    if ({bus.start_conv, bus.adc_ch_no, bus.res_valid, bus.res_ch, bus.res_data,
         bus.scan_done, busy, timeout_err} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid_conv: got %h want 000000", {bus.start_conv, bus.adc_ch_no,
               bus.res_valid, bus.res_ch, bus.res_data, bus.scan_done, busy, timeout_err});
    end
    repeat (3 * TMO) step();
    n_cmp++;
    if (res_log.size() != 0 || start_log.size() != 2) begin
      n_fail++; $display("FAIL reset_no_pulse: res=%0d starts=%0d want 0/2", res_log.size(), start_log.size());
    end
  endtask

  task automatic test_mask_zero();
    bit seen;
    cfg_ch_mask = '0;
    clear_logs();
    step();
    cfg_enable = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge mclk);
      if (busy !== 1'b0 || bus.start_conv !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL mask_zero_busy: busy/start went high, want 0"); end
    step();
    cfg_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_random_scans();
    test_interval();
    test_timeout();
    test_mask_change_and_disable();
    test_reset_mid_conv();
    test_mask_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_scan_seq.md
# adc_scan_seq

Autonomous channel-scan sequencer for the SAR ADC. It sits directly upstream of the SAR conversion core and drives its `start_conv` and `adc_ch_no` inputs. It consumes `conv_done` and `adc_result` and returns one averaged 8-bit result per enabled channel per scan. Software programs a channel mask, an averaging depth and a scan interval; the block then scans without further CPU involvement.

## Interface
- `TIMEOUT`, default 255: mclk cycles to wait for `conv_done` before declaring a conversion lost.
- `mclk`  in  1  block clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_enable`  in  1  scan enable (level).
- `cfg_ch_mask`  in  6  enabled channels; bit i = channel i.
- `cfg_avg_log2`  in  2  samples per channel = 2^cfg_avg_log2 (1/2/4/8).
- `cfg_interval`  in  16  `pulse1m_mclk` ticks between scan starts; 0 = back-to-back.
- `pulse1m_mclk`  in  1  1 MHz tick, one mclk cycle wide.
- `start_conv`  out  1  one-cycle conversion-start pulse to the SAR core.
- `adc_ch_no`  out  3  channel currently being converted.
- `conv_done`  in  1  SAR done level; completion = rising edge.
- `adc_result`  in  8  SAR result, valid while `conv_done` is high.
- `res_valid`  out  1  one-cycle pulse; `res_ch`/`res_data` valid.
- `res_ch`  out  3  channel of the result.
- `res_data`  out  8  averaged result.
- `scan_done`  out  1  one-cycle pulse after the last enabled channel of a scan.
- `busy`  out  1  high in any state except IDLE.
- `timeout_err`  out  1  sticky; set on timeout, cleared by `reset` or a `cfg_enable` 0→1 edge.

## Operation
- States: IDLE, WAIT_INT, START, CONV, NEXT.
- **IDLE**
  - When `cfg_enable`=1 and `cfg_ch_mask`≠0: latch the mask, avg_log2 and interval into shadow registers.
  - Select the lowest set mask bit as the channel, then go to START.
  - Mask = 0 means stay in IDLE with `busy`=0.
- **START**
  - Assert `start_conv` for one cycle.
  - Clear the timeout counter, then go to CONV.
- **CONV**
  - Wait for the `conv_done` rising edge, detected via a registered `conv_done` (`conv_done` & ~`conv_done_q`).
  - On the edge: acc += `adc_result`, sample count +1.
  - If count < 2^avg_log2, go to START (same channel). Otherwise go to NEXT.
  - Timeout: if TIMEOUT cycles elapse with no edge, set `timeout_err` and go to NEXT. The sample is discarded and no `res_valid` is issued for that channel.
- **NEXT**
  - If the final sample arrived: pulse `res_valid`, with `res_data` = acc >> avg_log2 (truncating) and `res_ch` = channel.
  - Clear acc and count.
  - Select the next higher set bit of the shadow mask and go to START.
  - If there is none: pulse `scan_done`. Then go to IDLE if `cfg_enable`=0 or the shadow interval = 0; otherwise go to WAIT_INT.
- **WAIT_INT**
  - The interval counter is loaded at scan start (first START after IDLE/WAIT_INT) and decrements on `pulse1m_mclk`.
  - When it reaches 0 and `cfg_enable`=1, re-latch the shadow config and go to START.
  - If `cfg_enable`=0, go to IDLE.
- Accumulator: 11 bits unsigned; 8×255 = 2040 cannot overflow.
- Config writes mid-scan have no effect until the next scan start (shadowed).
- `cfg_enable` falling mid-scan: the current conversion (through CONV exit) completes and its result is issued if it was the final sample. The block then goes to IDLE without a `scan_done` pulse.
- `conv_done` already high when entering CONV: not an edge; wait for the next one.

## Timing
- Reset values: `start_conv`=0, `adc_ch_no`=0, `res_valid`=0, `res_ch`=0, `res_data`=0, `scan_done`=0, `busy`=0, `timeout_err`=0. All counters, acc and shadows = 0. State = IDLE.
- Reset asserted mid-operation: all of the above apply on the next mclk edge. In-flight samples are dropped and no pulse is issued.
- IDLE → `start_conv` high: 1 cycle after `cfg_enable` is sampled high.
- `adc_ch_no` is stable from the START cycle until leaving CONV.
- Edge-detect cycle → `res_valid`: 1 cycle (NEXT). `res_data`/`res_ch` hold until the next `res_valid`.
- NEXT → next `start_conv`: 1 cycle.
- `scan_done` coincides with the last channel's `res_valid`.
- All outputs are registered.

## Test plan
- mask=6'b000101, avg_log2=0, interval=0. SAR model returns 0x40 for ch0 and 0xC3 for ch2. Required: `res_valid` ch0/0x40, then ch2/0xC3 with `scan_done` in the same cycle, then back-to-back repeat. `adc_ch_no` is never 1.
- avg_log2=3, ch3 samples 10,20,30,40,50,60,70,81 (sum 361). Required: exactly 8 `start_conv` pulses, then `res_data`=45 (361>>3), `res_ch`=3.
- interval=3, single channel. Required: the next scan's `start_conv` follows the 3rd `pulse1m_mclk` tick after scan start, not before.
- SAR model withholds `conv_done` on ch1. Required: `timeout_err`=1 after TIMEOUT cycles, no `res_valid` for ch1, scan continues to ch2. A `cfg_enable` 0→1 edge clears `timeout_err`.
- Change `cfg_ch_mask` mid-scan. Required: the current scan uses the old mask and the next scan uses the new one. Drop `cfg_enable` mid-CONV. Required: the result is issued (avg=1), no `scan_done`, then IDLE with `busy`=0.
- Assert `reset` for one cycle during CONV with avg=4. Required: all outputs at their reset values next cycle and no `res_valid` afterward. mask=0 with enable=1: `busy` stays 0.
